// File: rtl/cr16_control_pkg.sv
// Shared constants, instruction/state encodings and small helpers for the CR16-subset control sequencer.
package cr16_control_pkg;

    localparam int DATAWIDTH  = 16;
    localparam int REGWIDTH   = 4;
    localparam int ALUOPWIDTH = 4;
    localparam int PRSWIDTH   = 5;

    // psr bit positions, ordered {N,Z,F,L,C}
    localparam int PSR_N = 4;
    localparam int PSR_Z = 3;
    localparam int PSR_F = 2;
    localparam int PSR_L = 1;
    localparam int PSR_C = 0;

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_ANDI  = 4'b0001;
    localparam logic [3:0] OP_ORI   = 4'b0010;
    localparam logic [3:0] OP_XORI  = 4'b0011;
    localparam logic [3:0] OP_MEMJ  = 4'b0100;
    localparam logic [3:0] OP_ADDI  = 4'b0101;
    localparam logic [3:0] OP_LSHI  = 4'b1000;
    localparam logic [3:0] OP_SUBI  = 4'b1001;
    localparam logic [3:0] OP_CMPI  = 4'b1011;
    localparam logic [3:0] OP_BCOND = 4'b1100;
    localparam logic [3:0] OP_MOVI  = 4'b1101;
    localparam logic [3:0] OP_LUI   = 4'b1111;

    localparam logic [3:0] EXT_LOAD  = 4'b0000;
    localparam logic [3:0] EXT_STOR  = 4'b0100;
    localparam logic [3:0] EXT_JAL   = 4'b1000;
    localparam logic [3:0] EXT_JCOND = 4'b1100;

    localparam logic [3:0] ALU_MOV = 4'b1101;

    localparam logic [1:0] WB_PC1  = 2'd0;
    localparam logic [1:0] WB_COND = 2'd1;
    localparam logic [1:0] WB_ALU  = 2'd2;
    localparam logic [1:0] WB_MEM  = 2'd3;

    function automatic logic [15:0] sext8(input logic [7:0] v);
        return {{8{v[7]}}, v};
    endfunction

endpackage

// File: rtl/cr16_control_cond_check.sv
// cond_check: evaluates a 4-bit branch condition against the latched PSR.
module cond_check
    import cr16_control_pkg::*;
(
    input  logic [PRSWIDTH-1:0] psr,
    input  logic [3:0]          cond,
    output logic                taken
);

    // Condition decode; unlisted codes are never taken
    always_comb begin
        case (cond)
            4'b0000: taken = psr[PSR_Z];
            4'b0001: taken = ~psr[PSR_Z];
            4'b0010: taken = psr[PSR_C];
            4'b0011: taken = ~psr[PSR_C];
            4'b0100: taken = psr[PSR_L];
            4'b0101: taken = ~psr[PSR_L];
            4'b0110: taken = psr[PSR_N];
            4'b0111: taken = ~psr[PSR_N];
            4'b1000: taken = psr[PSR_F];
            4'b1001: taken = ~psr[PSR_F];
            4'b1110: taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/cr16_control.sv
// cr16_control: multi-cycle fetch/decode/exec/mem sequencer driving reg_alu.
// Optional feature: ILLEGAL_TRAP_EN sends undefined instructions to a sticky HALT state.
module cr16_control
    import cr16_control_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATAWIDTH-1:0]  mem_rdata,
    input  logic                  mem_ready,
    input  logic [DATAWIDTH-1:0]  dSrc,
    input  logic [DATAWIDTH-1:0]  dDst,
    input  logic [PRSWIDTH-1:0]   psrOut,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATAWIDTH-1:0]  mem_addr,
    output logic [DATAWIDTH-1:0]  mem_wdata,
    output logic                  write,
    output logic                  IMM_MUX,
    output logic [1:0]            WB_MUX,
    output logic [REGWIDTH-1:0]   rSrc,
    output logic [REGWIDTH-1:0]   rDst,
    output logic [ALUOPWIDTH-1:0] aluOp,
    output logic [DATAWIDTH-1:0]  imm,
    output logic [DATAWIDTH-1:0]  pc1,
    output logic [PRSWIDTH-1:0]   psr,
    output logic                  halted
);

    state_t state_r, state_nxt_s;
    logic [DATAWIDTH-1:0] pc_r, ir_r, pc1_s, pc_nxt_s;
    logic [PRSWIDTH-1:0]  psr_r;
    logic [3:0] op_s, ext_s;
    logic is_rtype_s, is_itype_s, is_lui_s, is_load_s, is_stor_s;
    logic is_jal_s, is_jcond_s, is_bcond_s, illegal_s, taken_s;
    logic wr_exec_s, latch_psr_s, dec_imm_mux_s;
    logic [1:0]  dec_wb_mux_s;
    logic [3:0]  dec_alu_op_s;
    logic [15:0] dec_imm_s;

    assign op_s       = ir_r[15:12];
    assign ext_s      = ir_r[7:4];
    assign pc1_s      = pc_r + 16'd1;
    assign is_rtype_s = (op_s == OP_RTYPE);
    assign is_lui_s   = (op_s == OP_LUI);
    assign is_bcond_s = (op_s == OP_BCOND);
    assign is_load_s  = (op_s == OP_MEMJ) && (ext_s == EXT_LOAD);
    assign is_stor_s  = (op_s == OP_MEMJ) && (ext_s == EXT_STOR);
    assign is_jal_s   = (op_s == OP_MEMJ) && (ext_s == EXT_JAL);
    assign is_jcond_s = (op_s == OP_MEMJ) && (ext_s == EXT_JCOND);

    cond_check u_cond_check (
        .psr   (psr_r),
        .cond  (ir_r[11:8]),
        .taken (taken_s)
    );

    // Opcode classification
    always_comb begin
        is_itype_s = 1'b0;
        illegal_s  = 1'b0;
        case (op_s)
            OP_ANDI, OP_ORI, OP_XORI, OP_ADDI,
            OP_LSHI, OP_SUBI, OP_CMPI, OP_MOVI: is_itype_s = 1'b1;
            4'b0110, 4'b0111, 4'b1010, 4'b1110: illegal_s = 1'b1;
            OP_MEMJ: illegal_s = ~(is_load_s | is_stor_s | is_jal_s | is_jcond_s);
            default: illegal_s = 1'b0;
        endcase
    end

    // Datapath controls decoded from IR
    always_comb begin
        dec_alu_op_s  = 4'h0;
        dec_imm_s     = 16'h0000;
        dec_imm_mux_s = 1'b0;
        dec_wb_mux_s  = WB_PC1;
        wr_exec_s     = 1'b0;
        latch_psr_s   = 1'b0;
        if (is_rtype_s) begin
            dec_alu_op_s = ext_s;
            dec_wb_mux_s = WB_ALU;
            wr_exec_s    = 1'b1;
            latch_psr_s  = 1'b1;
        end else if (is_itype_s) begin
            dec_alu_op_s  = op_s;
            dec_imm_s     = sext8(ir_r[7:0]);
            dec_imm_mux_s = 1'b1;
            dec_wb_mux_s  = WB_ALU;
            wr_exec_s     = (op_s != OP_CMPI);
            latch_psr_s   = 1'b1;
        end else if (is_lui_s) begin
            dec_alu_op_s  = ALU_MOV;
            dec_imm_s     = {ir_r[7:0], 8'h00};
            dec_imm_mux_s = 1'b1;
            dec_wb_mux_s  = WB_ALU;
            wr_exec_s     = 1'b1;
        end else if (is_load_s) begin
            dec_wb_mux_s = WB_MEM;
        end else if (is_jal_s) begin
            wr_exec_s = 1'b1;
        end else begin
            wr_exec_s = 1'b0;
        end
    end

    // PC value committed in EXEC
    always_comb begin
        if (is_jal_s || (is_jcond_s && taken_s)) begin
            pc_nxt_s = dSrc;
        end else if (is_bcond_s && taken_s) begin
            pc_nxt_s = pc_r + sext8(ir_r[7:0]);
        end else begin
            pc_nxt_s = pc1_s;
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_INIT;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // PC, IR and PSR registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_r  <= 16'h0000;
            ir_r  <= 16'h0000;
            psr_r <= 5'b00000;
        end else begin
            if (state_r == ST_FETCH && mem_ready) begin
                ir_r <= mem_rdata;
            end
            if (state_r == ST_EXEC) begin
                pc_r <= pc_nxt_s;
                if (latch_psr_s) begin
                    psr_r <= psrOut;
                end
            end
        end
    end

    // Next-state logic
    always_comb begin
        case (state_r)
            ST_INIT:   state_nxt_s = ST_FETCH;
            ST_FETCH:  state_nxt_s = mem_ready ? ST_DECODE : ST_FETCH;
`ifdef ILLEGAL_TRAP_EN
            ST_DECODE: state_nxt_s = illegal_s ? ST_HALT : ST_EXEC;
`else
            ST_DECODE: state_nxt_s = ST_EXEC;
`endif
            ST_EXEC:   state_nxt_s = (is_load_s || is_stor_s) ? ST_MEM : ST_FETCH;
            ST_MEM:    state_nxt_s = mem_ready ? ST_FETCH : ST_MEM;
            ST_HALT:   state_nxt_s = ST_HALT;
            default:   state_nxt_s = ST_INIT;
        endcase
    end

    // Output logic: decoded controls are only presented once IR holds the current instruction
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 16'h0000;
        mem_wdata = 16'h0000;
        write     = 1'b0;
        IMM_MUX   = 1'b0;
        WB_MUX    = WB_PC1;
        rSrc      = 4'h0;
        rDst      = 4'h0;
        aluOp     = 4'h0;
        imm       = 16'h0000;
        case (state_r)
            ST_FETCH: begin
                mem_req  = 1'b1;
                mem_addr = pc_r;
            end
            ST_DECODE, ST_EXEC, ST_MEM: begin
                rSrc    = ir_r[3:0];
                rDst    = ir_r[11:8];
                aluOp   = dec_alu_op_s;
                imm     = dec_imm_s;
                IMM_MUX = dec_imm_mux_s;
                WB_MUX  = dec_wb_mux_s;
                if (state_r == ST_EXEC) begin
                    write = wr_exec_s & ~illegal_s;
                end else if (state_r == ST_MEM) begin
                    mem_req   = 1'b1;
                    mem_addr  = dSrc;
                    mem_we    = is_stor_s;
                    mem_wdata = is_stor_s ? dDst : 16'h0000;
                    write     = is_load_s & mem_ready;
                end else begin
                    write = 1'b0;
                end
            end
            default: mem_req = 1'b0;
        endcase
    end

    assign pc1 = pc1_s;
    assign psr = psr_r;
`ifdef ILLEGAL_TRAP_EN
    assign halted = (state_r == ST_HALT);
`else
    assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_cr16_control.sv
// Self-checking bench for cr16_control: vector table for single instructions, hand-written memory/reset sequences.
module tb_cr16_control;
    import cr16_control_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] mem_rdata, dSrc, dDst;
    logic        mem_ready;
    logic [4:0]  psrOut;
    logic        mem_req, mem_we, write, IMM_MUX, halted;
    logic [15:0] mem_addr, mem_wdata, imm, pc1;
    logic [1:0]  WB_MUX;
    logic [3:0]  rSrc, rDst, aluOp;
    logic [4:0]  psr;

    cr16_control dut (
        .clk(clk), .reset(reset), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .dSrc(dSrc), .dDst(dDst), .psrOut(psrOut), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .write(write), .IMM_MUX(IMM_MUX),
        .WB_MUX(WB_MUX), .rSrc(rSrc), .rDst(rDst), .aluOp(aluOp), .imm(imm),
        .pc1(pc1), .psr(psr), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] dsrc;
        logic [4:0]  psr_in;
        logic [3:0]  aluop;
        logic [15:0] imm;
        logic        imm_mux;
        logic [1:0]  wb;
        logic [3:0]  rdst;
        logic        wr;
        logic [4:0]  psr_exp;
        logic [15:0] next_pc;
    } vec_t;

    vec_t        vecs [15];
    logic [5:0]  wq [$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] exp_pc;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_fetch(input logic [15:0] instr);
        chk("fetch_req", {15'd0, mem_req}, 16'd1);
        chk("fetch_addr", mem_addr, exp_pc);
        mem_rdata = instr;
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
    endtask

    // Write-pulse scoreboard: each pulse must match the next expected {rDst, WB_MUX}
    always @(negedge clk) begin
        if (reset === 1'b0 && write === 1'b1) begin
            n_vec++;
            if (wq.size() == 0) begin
                n_err++;
                $display("FAIL write_extra: unexpected write rDst=%h WB_MUX=%h", rDst, WB_MUX);
            end else begin
                logic [5:0] e;
                e = wq.pop_front();
                if ({rDst, WB_MUX} !== e) begin
                    n_err++;
                    $display("FAIL write_dest: got %h, expected %h", {rDst, WB_MUX}, e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        //            instr     dsrc      psr_in    aluop  imm       imx   wb     rdst   wr    psr_exp   next_pc
        vecs[0]  = '{16'h5305, 16'h0000, 5'b00000, 4'h5, 16'h0005, 1'b1, 2'd2, 4'h3, 1'b1, 5'b00000, 16'h0001};
        vecs[1]  = '{16'hF1AB, 16'h0000, 5'b10111, 4'hD, 16'hAB00, 1'b1, 2'd2, 4'h1, 1'b1, 5'b00000, 16'h0002};
        vecs[2]  = '{16'hB2FF, 16'h0000, 5'b01000, 4'hB, 16'hFFFF, 1'b1, 2'd2, 4'h2, 1'b0, 5'b01000, 16'h0003};
        vecs[3]  = '{16'h0A15, 16'h0000, 5'b01001, 4'h1, 16'h0000, 1'b0, 2'd2, 4'hA, 1'b1, 5'b01001, 16'h0004};
        vecs[4]  = '{16'hCE0C, 16'h0000, 5'b10111, 4'h0, 16'h0000, 1'b0, 2'd0, 4'hE, 1'b0, 5'b01001, 16'h0010};
        vecs[5]  = '{16'hC0FE, 16'h0000, 5'b10111, 4'h0, 16'h0000, 1'b0, 2'd0, 4'h0, 1'b0, 5'b01001, 16'h000E};
        vecs[6]  = '{16'hB000, 16'h0000, 5'b00000, 4'hB, 16'h0000, 1'b1, 2'd2, 4'h0, 1'b0, 5'b00000, 16'h000F};
        vecs[7]  = '{16'hC0FE, 16'h0000, 5'b10111, 4'h0, 16'h0000, 1'b0, 2'd0, 4'h0, 1'b0, 5'b00000, 16'h0010};
        vecs[8]  = '{16'hC0FE, 16'h0000, 5'b10111, 4'h0, 16'h0000, 1'b0, 2'd0, 4'h0, 1'b0, 5'b00000, 16'h0011};
        vecs[9]  = '{16'h4581, 16'h0040, 5'b10111, 4'h0, 16'h0000, 1'b0, 2'd0, 4'h5, 1'b1, 5'b00000, 16'h0040};
        vecs[10] = '{16'h41C2, 16'h0080, 5'b10111, 4'h0, 16'h0000, 1'b0, 2'd0, 4'h1, 1'b0, 5'b00000, 16'h0080};
        vecs[11] = '{16'h40C2, 16'h0100, 5'b10111, 4'h0, 16'h0000, 1'b0, 2'd0, 4'h0, 1'b0, 5'b00000, 16'h0081};
        vecs[12] = '{16'hCA05, 16'h0000, 5'b10111, 4'h0, 16'h0000, 1'b0, 2'd0, 4'hA, 1'b0, 5'b00000, 16'h0082};
        vecs[13] = '{16'h4EC3, 16'hFFFF, 5'b10111, 4'h0, 16'h0000, 1'b0, 2'd0, 4'hE, 1'b0, 5'b00000, 16'hFFFF};
        vecs[14] = '{16'h5101, 16'h0000, 5'b00000, 4'h5, 16'h0001, 1'b1, 2'd2, 4'h1, 1'b1, 5'b00000, 16'h0000};

        reset = 1'b1; mem_ready = 1'b1; mem_rdata = 16'h0000;
        dSrc = 16'h0000; dDst = 16'h0000; psrOut = 5'b00000;
        tick(); tick();
        chk("rst_mem_req", {15'd0, mem_req}, 16'd0);
        chk("rst_write", {15'd0, write}, 16'd0);
        chk("rst_pc1", pc1, 16'h0001);
        chk("rst_psr", {11'd0, psr}, 16'd0);
        chk("rst_mem_addr", mem_addr, 16'h0000);
        chk("rst_wb_mux", {14'd0, WB_MUX}, 16'd0);
        chk("rst_imm", imm, 16'h0000);
        chk("rst_halted", {15'd0, halted}, 16'd0);
        reset = 1'b0;
        #1;
        chk("init_no_req", {15'd0, mem_req}, 16'd0);
        tick();
        exp_pc = 16'h0000;

        for (int i = 0; i < 15; i++) begin
            do_fetch(vecs[i].instr);
            chk($sformatf("v%0d_aluop", i), {12'd0, aluOp}, {12'd0, vecs[i].aluop});
            chk($sformatf("v%0d_imm", i), imm, vecs[i].imm);
            chk($sformatf("v%0d_imm_mux", i), {15'd0, IMM_MUX}, {15'd0, vecs[i].imm_mux});
            chk($sformatf("v%0d_wb_mux", i), {14'd0, WB_MUX}, {14'd0, vecs[i].wb});
            chk($sformatf("v%0d_rdst", i), {12'd0, rDst}, {12'd0, vecs[i].rdst});
            chk($sformatf("v%0d_dec_write", i), {15'd0, write}, 16'd0);
            psrOut = vecs[i].psr_in;
            dSrc   = vecs[i].dsrc;
            if (vecs[i].wr) wq.push_back({vecs[i].rdst, vecs[i].wb});
            tick();
            chk($sformatf("v%0d_exec_write", i), {15'd0, write}, {15'd0, vecs[i].wr});
            chk($sformatf("v%0d_pc1", i), pc1, exp_pc + 16'd1);
            tick();
            chk($sformatf("v%0d_psr", i), {11'd0, psr}, {11'd0, vecs[i].psr_exp});
            exp_pc = vecs[i].next_pc;
        end

        // LOAD with three wait cycles
        do_fetch(16'h4302);
        chk("ld_wb_mux", {14'd0, WB_MUX}, 16'd3);
        dSrc = 16'h1234;
        wq.push_back({4'h3, 2'd3});
        tick();
        chk("ld_exec_write", {15'd0, write}, 16'd0);
        tick();
        for (int k = 0; k < 3; k++) begin
            chk("ld_wait_req", {15'd0, mem_req}, 16'd1);
            chk("ld_wait_addr", mem_addr, 16'h1234);
            chk("ld_wait_we", {15'd0, mem_we}, 16'd0);
            chk("ld_wait_write", {15'd0, write}, 16'd0);
            tick();
        end
        mem_ready = 1'b1;
        #1;
        chk("ld_ready_write", {15'd0, write}, 16'd1);
        tick();
        mem_ready = 1'b0;
        exp_pc = 16'h0001;

        // Zero-wait STOR
        do_fetch(16'h4741);
        dSrc = 16'h2000; dDst = 16'hBEEF;
        tick();
        chk("st_exec_write", {15'd0, write}, 16'd0);
        tick();
        chk("st_req", {15'd0, mem_req}, 16'd1);
        chk("st_we", {15'd0, mem_we}, 16'd1);
        chk("st_addr", mem_addr, 16'h2000);
        chk("st_wdata", mem_wdata, 16'hBEEF);
        mem_ready = 1'b1;
        #1;
        chk("st_write", {15'd0, write}, 16'd0);
        tick();
        mem_ready = 1'b0;
        exp_pc = 16'h0002;

        // Undefined opcode
        do_fetch(16'h7000);
`ifdef ILLEGAL_TRAP_EN
        tick();
        mem_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("trap_halted", {15'd0, halted}, 16'd1);
            chk("trap_no_req", {15'd0, mem_req}, 16'd0);
            tick();
        end
        mem_ready = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        exp_pc = 16'h0000;
`else
        tick();
        chk("nop_write", {15'd0, write}, 16'd0);
        chk("nop_halted", {15'd0, halted}, 16'd0);
        tick();
        exp_pc = 16'h0003;
`endif

        // Reset while a LOAD is waiting in MEM
        do_fetch(16'h4302);
        dSrc = 16'h1234;
        tick();
        tick();
        chk("mid_mem_req", {15'd0, mem_req}, 16'd1);
        reset = 1'b1;
        #1;
        chk("abort_req", {15'd0, mem_req}, 16'd0);
        chk("abort_pc1", pc1, 16'h0001);
        tick();
        reset = 1'b0;
        tick();
        exp_pc = 16'h0000;
        chk("post_rst_req", {15'd0, mem_req}, 16'd1);
        chk("post_rst_addr", mem_addr, exp_pc);

        chk("write_pending", wq.size(), 16'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
